calc_op_writer: RTL and testbench
=================================

Name: calc_op_writer

Overview:
- Write-side controller for the calculator register bank.
- Accepts an operation command while mode is COMPUTE and combines the selected register's current value with the switch operand.
- Produces the single-cycle load / new_value / overflow strobe that the register bank consumes.
- Add, subtract and set take one execute cycle. Multiply uses an iterative shift-add multiplier.

Parameters:
- WIDTH, 16, data width of register values and operand (signed two's complement).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- mode  in  2  calculator mode; 1 = COMPUTE, 2 = REGSEL, others idle
- start  in  1  one-cycle command pulse (debounced centre button)
- op_sel  in  2  0 ADD, 1 SUB, 2 MUL, 3 SET
- operand  in  WIDTH  signed switch operand B
- current_value  in  WIDTH  signed value of selected register (operand A)
- load  out  1  one-cycle write strobe to register bank
- new_value  out  WIDTH  signed result; valid when load=1
- overflow  out  1  asserted with load when result exceeded signed WIDTH range
- busy  out  1  high from accept until load or abort

Behaviour:
- Reset: async, active-high.
  - Outputs during reset: load=0, overflow=0, busy=0, new_value=0, state=IDLE.
  - Multiplier datapath cleared.
- States: IDLE, EXEC, MUL, WRITE.
- IDLE:
  - start=1 and mode==1 → accept. Latch A=current_value, B=operand, op=op_sel; busy=1.
  - Next state: EXEC for ADD/SUB/SET; MUL for MUL.
  - start while mode!=1 is ignored.
- EXEC (1 cycle):
  - Compute (WIDTH+1)-bit sign-extended result: ADD A+B, SUB A−B, SET B.
  - Go to WRITE.
- MUL (WIDTH cycles):
  - Unsigned shift-add on |A| and |B|; magnitude of −32768 is 0x8000 unsigned.
  - Product is 2·WIDTH unsigned; negate if sign(A)≠sign(B), giving a 2·WIDTH signed result.
  - Go to WRITE after exactly WIDTH iterations.
- WRITE (1 cycle):
  - load=1; new_value = low WIDTH bits of result (wraps, never saturates).
  - overflow=1 iff the full result is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]. SET never overflows.
  - Next cycle: IDLE, busy=0, load=0, overflow=0.
- Latency, with accept at cycle 0:
  - ADD/SUB/SET: load at cycle 2.
  - MUL: load at cycle WIDTH+2 (18).
- new_value holds its last written value between loads.
- Boundaries:
  - start while busy: ignored; no queuing.
  - mode leaves 1 while in EXEC or MUL: abort to IDLE next cycle, no load, busy=0. The bank's selected register can only change in REGSEL, so the write target is always the register selected at accept.
  - mode change in the WRITE cycle does not cancel that load.
  - A and B are snapshotted at accept. Changes to current_value or operand during busy have no effect.
  - rst asserted mid-operation: immediate return to IDLE, no load issued.
  - −32768 × −1 → +32768: overflow=1, new_value=−32768.
- load and overflow are registered outputs, driven directly from flops with no combinational path from inputs.

Decomposition:
- Package calc_pkg:
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_SET
  - mode constants MODE_COMPUTE=1, MODE_REGSEL=2
  - state encoding
  - WIDTH default
  - The register bank shares this package for its mode constants.
- Sub-module seq_mult_u:
  - Unsigned iterative multiplier.
  - Ports: clk, rst, go, a, b, done, product[2·WIDTH−1:0].
  - Runs WIDTH cycles.
- Sign handling and overflow detection stay in calc_op_writer.

Test Plan:
- ADD: A=100, B=23, mode=1, start pulse at cycle 0 → load=1 only at cycle 2, new_value=123, overflow=0; busy high cycles 1–2.
- Add overflow: A=32767, B=1, ADD → new_value=−32768 (0x8000), overflow=1 with load. Also SUB with A=−32768, B=1 → new_value=32767, overflow=1.
- MUL:
  - A=−7, B=6 → load at cycle 18, new_value=−42, overflow=0.
  - A=−300, B=200 → new_value=5536 (0x15A0), overflow=1.
  - A=−32768, B=−1 → new_value=−32768, overflow=1.
- Busy/snapshot: during MUL, pulse start again with op_sel=ADD and change current_value → exactly one load at cycle 18 with the original product; no second load.
- Abort: start MUL, switch mode to 2 at cycle 5 → no load ever; busy=0 at cycle 6. Repeat with rst pulsed at cycle 9 → all outputs 0 immediately; IDLE afterwards; a new ADD then works normally.
- Gating: start with mode=2 or mode=0 → no busy, no load; SET with B=−5 → new_value=−5, overflow=0.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg
// Shared definitions for the calculator datapath: the default data width,
// the calculator mode encoding, the operation codes and the write-controller
// state encoding. The register bank imports this package for the mode
// constants, so both sides agree on what COMPUTE and REGSEL mean.
package calc_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [1:0] MODE_COMPUTE = 2'd1;
  localparam logic [1:0] MODE_REGSEL  = 2'd2;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_SET = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MUL   = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_mult_u.sv
// seq_mult_u
// Unsigned iterative shift-add multiplier. A go pulse captures a and b and
// clears the accumulator; WIDTH iterations follow, one per clock. done is
// high for the cycle after the last iteration, while product holds the
// full 2*WIDTH-bit unsigned product. A new go restarts the unit at any time.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset, clears the datapath
//   go       start pulse, captures a and b
//   a, b     unsigned factors (WIDTH bits)
//   done     product valid
//   product  unsigned product (2*WIDTH bits)
module seq_mult_u
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcandQ, mcandD;
  logic [WIDTH-1:0]   mplierQ, mplierD;
  logic [2*WIDTH-1:0] accQ, accD;
  logic [CW-1:0]      cntQ, cntD;
  logic               runQ, runD;

  // Each iteration adds the shifted multiplicand when the current multiplier
  // LSB is set, then shifts both operands. The run flag drops one cycle after
  // the count reaches zero so done is a single-cycle indication.
  always_comb begin
    mcandD  = mcandQ;
    mplierD = mplierQ;
    accD    = accQ;
    cntD    = cntQ;
    runD    = runQ;
    if (go) begin
      mcandD  = {{WIDTH{1'b0}}, a};
      mplierD = b;
      accD    = '0;
      cntD    = CW'(WIDTH);
      runD    = 1'b1;
    end else if (runQ) begin
      if (cntQ != '0) begin
        if (mplierQ[0]) begin
          accD = accQ + mcandQ;
        end
        mcandD  = mcandQ << 1;
        mplierD = mplierQ >> 1;
        cntD    = cntQ - CW'(1);
      end else begin
        runD = 1'b0;
      end
    end
  end

  // Datapath registers, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcandQ  <= '0;
      mplierQ <= '0;
      accQ    <= '0;
      cntQ    <= '0;
      runQ    <= 1'b0;
    end else begin
      mcandQ  <= mcandD;
      mplierQ <= mplierD;
      accQ    <= accD;
      cntQ    <= cntD;
      runQ    <= runD;
    end
  end

  assign done    = runQ && (cntQ == '0);
  assign product = accQ;

endmodule

// File: rtl/calc_op_writer.sv
// calc_op_writer
// Write-side controller for the calculator register bank. In COMPUTE mode a
// start pulse snapshots the selected register (A), the switch operand (B)
// and the operation, then produces a one-cycle load strobe with the new
// value and an overflow flag. ADD/SUB/SET take one execute cycle; MUL runs
// the iterative unsigned multiplier on |A| and |B| and fixes the sign here.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mode            calculator mode (1 = COMPUTE)
//   start           one-cycle command pulse
//   op_sel          0 ADD, 1 SUB, 2 MUL, 3 SET
//   operand         signed operand B
//   current_value   signed operand A (selected register)
//   load            registered one-cycle write strobe
//   new_value       signed result, held between loads
//   overflow        registered, valid with load
//   busy            high from accept until load or abort
module calc_op_writer
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] current_value,
  output logic             load,
  output logic [WIDTH-1:0] new_value,
  output logic             overflow,
  output logic             busy
);

  state_t             stateQ, stateD;
  op_t                opQ, opD;
  logic [WIDTH-1:0]   aQ, aD, bQ, bD;
  logic               negQ, negD;
  logic               loadQ, loadD;
  logic               ovfQ, ovfD;
  logic [WIDTH-1:0]   valueQ, valueD;

  logic               mulGo, mulDone;
  logic [2*WIDTH-1:0] mulProduct;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     execSum;
  logic [2*WIDTH-1:0] result;
  logic               resultOvf;

  // The multiplier is started on the accept edge straight from the inputs so
  // that its WIDTH iterations finish in time for the load at cycle WIDTH+2.
  // Negating the most negative value wraps to 2^(WIDTH-1), which is exactly
  // the required unsigned magnitude.
  assign aMag = current_value[WIDTH-1] ? -current_value : current_value;
  assign bMag = operand[WIDTH-1] ? -operand : operand;

  seq_mult_u #(
    .WIDTH(WIDTH)
  ) uMult (
    .clk    (clk),
    .rst    (rst),
    .go     (mulGo),
    .a      (aMag),
    .b      (bMag),
    .done   (mulDone),
    .product(mulProduct)
  );

  // Result is formed at 2*WIDTH bits in both paths so one range check
  // covers every operation: it overflows when the bits above the signed
  // WIDTH range are not all copies of the WIDTH-bit sign bit.
  always_comb begin
    case (opQ)
      OP_ADD:  execSum = {aQ[WIDTH-1], aQ} + {bQ[WIDTH-1], bQ};
      OP_SUB:  execSum = {aQ[WIDTH-1], aQ} - {bQ[WIDTH-1], bQ};
      default: execSum = {bQ[WIDTH-1], bQ};
    endcase
    if (stateQ == ST_MUL) begin
      result = negQ ? -mulProduct : mulProduct;
    end else begin
      result = {{(WIDTH-1){execSum[WIDTH]}}, execSum};
    end
    resultOvf = (result[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){result[WIDTH-1]}});
  end

  // Next-state logic. Leaving COMPUTE while executing abandons the command
  // with no write; once in WRITE the strobe is already registered and goes
  // out regardless of mode.
  always_comb begin
    stateD = stateQ;
    opD    = opQ;
    aD     = aQ;
    bD     = bQ;
    negD   = negQ;
    loadD  = 1'b0;
    ovfD   = 1'b0;
    valueD = valueQ;
    mulGo  = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (start && (mode == MODE_COMPUTE)) begin
          aD   = current_value;
          bD   = operand;
          opD  = op_t'(op_sel);
          negD = current_value[WIDTH-1] ^ operand[WIDTH-1];
          if (op_t'(op_sel) == OP_MUL) begin
            mulGo  = 1'b1;
            stateD = ST_MUL;
          end else begin
            stateD = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (mode != MODE_COMPUTE) begin
          stateD = ST_IDLE;
        end else begin
          stateD = ST_WRITE;
          loadD  = 1'b1;
          ovfD   = resultOvf;
          valueD = result[WIDTH-1:0];
        end
      end
      ST_MUL: begin
        if (mode != MODE_COMPUTE) begin
          stateD = ST_IDLE;
        end else if (mulDone) begin
          stateD = ST_WRITE;
          loadD  = 1'b1;
          ovfD   = resultOvf;
          valueD = result[WIDTH-1:0];
        end
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  // State and output registers; load and overflow come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= ST_IDLE;
      opQ    <= OP_ADD;
      aQ     <= '0;
      bQ     <= '0;
      negQ   <= 1'b0;
      loadQ  <= 1'b0;
      ovfQ   <= 1'b0;
      valueQ <= '0;
    end else begin
      stateQ <= stateD;
      opQ    <= opD;
      aQ     <= aD;
      bQ     <= bD;
      negQ   <= negD;
      loadQ  <= loadD;
      ovfQ   <= ovfD;
      valueQ <= valueD;
    end
  end

  assign load      = loadQ;
  assign overflow  = ovfQ;
  assign new_value = valueQ;
  assign busy      = (stateQ != ST_IDLE);

endmodule

// File: tb/tb_calc_op_writer.sv
// tb_calc_op_writer
// Self-checking bench for calc_op_writer: a table of directed vectors,
// hand-written abort/reset/snapshot sequences and randomized operations
// checked against an integer-arithmetic reference model.
module tb_calc_op_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        start;
  logic [1:0]  op_sel;
  logic [15:0] operand;
  logic [15:0] current_value;
  logic        load;
  logic [15:0] new_value;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int          nLoads;
  int          loadCyc;
  logic [15:0] loadVal;
  logic        loadOvf;
  logic        busyLog [0:24];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] expVal;
    logic        expOvf;
    int          expLat;
  } vec_t;

  vec_t vecs [12];

  calc_op_writer #(
    .WIDTH(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .start        (start),
    .op_sel       (op_sel),
    .operand      (operand),
    .current_value(current_value),
    .load         (load),
    .new_value    (new_value),
    .overflow     (overflow),
    .busy         (busy)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point; every check steps the counters here.
  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Reference model from the arithmetic rules: exact integer result,
  // low 16 bits written, overflow when outside the signed 16-bit range.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       output logic [15:0] v, output logic ov, output int lat);
    longint r;
    case (op)
      2'd0:    r = longint'($signed(a)) + longint'($signed(b));
      2'd1:    r = longint'($signed(a)) - longint'($signed(b));
      2'd2:    r = longint'($signed(a)) * longint'($signed(b));
      default: r = longint'($signed(b));
    endcase
    v   = r[15:0];
    ov  = (r < -32768) || (r > 32767);
    lat = (op == 2'd2) ? 18 : 2;
  endtask

  // Issues a start in cycle 0 and watches cycles 1..24. Optional injections:
  // mode to REGSEL in cycle modeCyc, rst pulse in cycle rstCyc, a second
  // start with altered inputs in cycle distCyc (-1 disables each).
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                               input logic [1:0] md, input int modeCyc, input int rstCyc,
                               input int distCyc);
    nLoads  = 0;
    loadCyc = -1;
    loadVal = '0;
    loadOvf = 1'b0;
    current_value = a;
    operand       = b;
    op_sel        = op;
    mode          = md;
    start         = 1'b1;
    busyLog[0]    = busy;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      busyLog[c] = busy;
      if (load) begin
        nLoads++;
        loadCyc = c;
        loadVal = new_value;
        loadOvf = overflow;
      end
      if (c == modeCyc) begin
        mode = 2'd2;
      end
      if (c == distCyc) begin
        start         = 1'b1;
        op_sel        = 2'd0;
        current_value = 16'h1234;
        operand       = 16'h0111;
      end
      if (c == rstCyc) begin
        rst = 1'b1;
        #1;
        checkOutput("rstLoad", 32'(load), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstOvf", 32'(overflow), 0);
        checkOutput("rstValue", 32'(new_value), 0);
        rst = 1'b0;
      end
    end
  endtask

  task automatic checkOp(input string tag, input logic [15:0] expVal, input logic expOvf,
                         input int expLat);
    checkOutput({tag, "_loads"}, nLoads, 1);
    checkOutput({tag, "_latency"}, loadCyc, expLat);
    checkOutput({tag, "_value"}, 32'(loadVal), 32'(expVal));
    checkOutput({tag, "_ovf"}, 32'(loadOvf), 32'(expOvf));
    checkOutput({tag, "_busyFirst"}, 32'(busyLog[1]), 1);
    checkOutput({tag, "_busyWrite"}, 32'(busyLog[expLat]), 1);
    checkOutput({tag, "_busyAfter"}, 32'(busyLog[expLat+1]), 0);
  endtask

  initial begin
    logic [15:0] ra, rb, ev;
    logic [1:0]  rop;
    logic        eo;
    int          el;

    vecs[0]  = '{16'd100,  16'd23,   2'd0, 16'd123,  1'b0, 2};
    vecs[1]  = '{16'h7FFF, 16'h0001, 2'd0, 16'h8000, 1'b1, 2};
    vecs[2]  = '{16'h8000, 16'h0001, 2'd1, 16'h7FFF, 1'b1, 2};
    vecs[3]  = '{16'hFFF9, 16'd6,    2'd2, 16'hFFD6, 1'b0, 18};
    vecs[4]  = '{16'hFED4, 16'h00C8, 2'd2, 16'h15A0, 1'b1, 18};
    vecs[5]  = '{16'h8000, 16'hFFFF, 2'd2, 16'h8000, 1'b1, 18};
    vecs[6]  = '{16'd0,    16'hFFFB, 2'd3, 16'hFFFB, 1'b0, 2};
    vecs[7]  = '{16'd5,    16'hFFFD, 2'd1, 16'd8,    1'b0, 2};
    vecs[8]  = '{16'h00B5, 16'h00B5, 2'd2, 16'h7FF9, 1'b0, 18};
    vecs[9]  = '{16'd0,    16'h8000, 2'd2, 16'h0000, 1'b0, 18};
    vecs[10] = '{16'h7FFF, 16'h8000, 2'd3, 16'h8000, 1'b0, 2};
    vecs[11] = '{16'h8000, 16'h8000, 2'd0, 16'h0000, 1'b1, 2};

    rst           = 1'b1;
    mode          = 2'd0;
    start         = 1'b0;
    op_sel        = 2'd0;
    operand       = '0;
    current_value = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetLoad", 32'(load), 0);
    checkOutput("resetOvf", 32'(overflow), 0);
    checkOutput("resetBusy", 32'(busy), 0);
    checkOutput("resetValue", 32'(new_value), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, 2'd1, -1, -1, -1);
      checkOp($sformatf("vec%0d", i), vecs[i].expVal, vecs[i].expOvf, vecs[i].expLat);
    end

    $display("[TB] held value between loads");
    checkOutput("holdValue", 32'(new_value), 32'(16'h0000));

    $display("[TB] busy snapshot");
    applyStimulus(16'hFFF9, 16'd6, 2'd2, 2'd1, -1, -1, 3);
    checkOutput("snap_loads", nLoads, 1);
    checkOutput("snap_latency", loadCyc, 18);
    checkOutput("snap_value", 32'(loadVal), 32'(16'hFFD6));
    checkOutput("snap_ovf", 32'(loadOvf), 0);

    $display("[TB] abort in MUL");
    applyStimulus(16'hFFF9, 16'd6, 2'd2, 2'd1, 5, -1, -1);
    checkOutput("abortMul_loads", nLoads, 0);
    checkOutput("abortMul_busy5", 32'(busyLog[5]), 1);
    checkOutput("abortMul_busy6", 32'(busyLog[6]), 0);

    $display("[TB] abort in EXEC");
    applyStimulus(16'd100, 16'd23, 2'd0, 2'd1, 1, -1, -1);
    checkOutput("abortExec_loads", nLoads, 0);
    checkOutput("abortExec_busy2", 32'(busyLog[2]), 0);

    $display("[TB] mode change during WRITE");
    applyStimulus(16'd100, 16'd23, 2'd0, 2'd1, 2, -1, -1);
    checkOutput("writeMode_loads", nLoads, 1);
    checkOutput("writeMode_value", 32'(loadVal), 123);

    $display("[TB] reset mid-multiply");
    applyStimulus(16'hFED4, 16'h00C8, 2'd2, 2'd1, -1, 9, -1);
    checkOutput("rstMul_loads", nLoads, 0);
    checkOutput("rstMul_busy10", 32'(busyLog[10]), 0);
    applyStimulus(16'd100, 16'd23, 2'd0, 2'd1, -1, -1, -1);
    checkOp("postRst", 16'd123, 1'b0, 2);

    $display("[TB] mode gating");
    applyStimulus(16'd100, 16'd23, 2'd0, 2'd2, -1, -1, -1);
    checkOutput("gateRegsel_loads", nLoads, 0);
    checkOutput("gateRegsel_busy", 32'(busyLog[1]), 0);
    applyStimulus(16'd100, 16'd23, 2'd2, 2'd0, -1, -1, -1);
    checkOutput("gateIdle_loads", nLoads, 0);
    checkOutput("gateIdle_busy", 32'(busyLog[1]), 0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 2'($urandom_range(0, 3));
      if (i % 3 == 0) begin
        ra = 16'($signed(8'($urandom)));
        rb = 16'($signed(8'($urandom)));
      end
      model(ra, rb, rop, ev, eo, el);
      applyStimulus(ra, rb, rop, 2'd1, -1, -1, -1);
      checkOp($sformatf("rand%0d", i), ev, eo, el);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
